// File: rtl/data_mem_arbiter.sv
// Multi-core request arbiter in front of the single-port data_memory: one grant per cycle,
// registered ack/rdata. Define DATA_MEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module data_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_ack,
  output logic [NUM_CORES*DATA_W-1:0]   core_rdata,
  output logic                          mem_write,
  output logic                          mem_read,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_data_in,
  input  logic [DATA_W-1:0]             mem_data_out
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0] elig_p0;
  logic                 vld_p0;
  logic [IDX_W-1:0]     gnt_p0;
  logic [NUM_CORES-1:0] gnt_onehot_p0;

  // A core sitting in its ack cycle still shows the finished transaction, so it is masked.
  assign elig_p0 = core_req & ~core_ack;

  // Stage p0: combinational arbitration
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    vld_p0 = 1'b0;
    gnt_p0 = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (elig_p0[k]) begin
        vld_p0 = 1'b1;
        gnt_p0 = IDX_W'(k);
      end
    end
    if (reset) vld_p0 = 1'b0;
  end
`else
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] cand_p0;

  // Walk the offsets downward so the last hit is the first core after last_grant.
  always_comb begin
    vld_p0  = 1'b0;
    gnt_p0  = '0;
    cand_p0 = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      cand_p0 = IDX_W'((int'(last_grant) + k) % NUM_CORES);
      if (elig_p0[cand_p0]) begin
        vld_p0 = 1'b1;
        gnt_p0 = cand_p0;
      end
    end
    if (reset) vld_p0 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDX_W'(NUM_CORES - 1);
    end else if (vld_p0) begin
      last_grant <= gnt_p0;
    end
  end
`endif

  assign gnt_onehot_p0 = vld_p0 ? (NUM_CORES'(1) << gnt_p0) : '0;

  always_comb begin
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    if (vld_p0) begin
      mem_write   = core_we[gnt_p0];
      mem_read    = ~core_we[gnt_p0];
      mem_address = core_addr[int'(gnt_p0)*ADDR_W +: ADDR_W];
      mem_data_in = core_wdata[int'(gnt_p0)*DATA_W +: DATA_W];
    end
  end

  // Stage p1: registered completion back to the cores
  always_ff @(posedge clk) begin
    if (reset) begin
      core_ack   <= '0;
      core_rdata <= '0;
    end else begin
      core_ack <= gnt_onehot_p0;
      if (vld_p0 && !core_we[gnt_p0]) begin
        core_rdata[int'(gnt_p0)*DATA_W +: DATA_W] <= mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: behavioural memory fixture plus a transaction-level
// reference model of grants, acks, read data and memory contents.
module tb_data_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    core_req, core_we, core_ack;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata, core_rdata;
  logic            mem_write, mem_read;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_data_in, mem_data_out;

  data_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
    .core_rdata(core_rdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // data_memory stand-in: combinational read, write on the clock edge, preload port for setup
  logic [DW-1:0] mem [0:65535];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write) mem[mem_address] <= mem_data_in;
  end
  assign mem_data_out = mem[mem_address];

  // reference model state
  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] exp_rdata [N];
  logic [N-1:0]  exp_ack, ack_prev;
  int            exp_last;
  int            checks = 0;
  int            errors = 0;

  function automatic int model_grant();
    logic [N-1:0] elig;
    int c;
    elig = core_req & ~exp_ack;
    if (reset) return -1;
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (elig[k]) return k;
`else
    for (int k = 1; k <= N; k++) begin
      c = (exp_last + k) % N;
      if (elig[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic cycle();
    int g;
    logic [AW-1:0] a;
    g = model_grant();
    @(posedge clk);
    ack_prev = exp_ack;
    exp_ack  = '0;
    if (reset) begin
      for (int i = 0; i < N; i++) exp_rdata[i] = '0;
      exp_last = N - 1;
    end else if (g >= 0) begin
      exp_ack[g] = 1'b1;
      exp_last   = g;
      a = core_addr[g*AW +: AW];
      if (core_we[g]) ref_mem[a] = core_wdata[g*DW +: DW];
      else exp_rdata[g] = ref_mem[a];
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
  endtask

  task automatic set_txn(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req[i] = 1'b1;
    core_we[i]  = we;
    core_addr[i*AW +: AW]  = a;
    core_wdata[i*DW +: DW] = d;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    cycle();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    for (int a = 0; a < 16; a++) preload(AW'(a), DW'(a + 1));
    preload(16'd100, 16'd10);
    preload(16'd50, 16'd77);
    set_txn(3, 1'b1, 16'd50, 16'd55);
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
    cycle();
    checks++; if (core_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", core_ack); end
    checks++; if (core_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", core_rdata); end
    checks++; if (mem[50] !== 16'd77) begin errors++; $display("FAIL reset_no_write got %0d want 77", mem[50]); end
  endtask

  task automatic test_single_read();
    reset_dut();
    set_txn(1, 1'b0, 16'd100, 16'd0);
    #1;
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL single_rw got r%b w%b want r1 w0", mem_read, mem_write); end
    checks++; if (mem_address !== 16'd100) begin errors++; $display("FAIL single_addr got %0d want 100", mem_address); end
    cycle();
    checks++; if (core_ack !== 4'b0010) begin errors++; $display("FAIL single_ack got %b want 0010", core_ack); end
    checks++; if (core_rdata[1*DW +: DW] !== 16'd10) begin errors++; $display("FAIL single_rdata got %0d want 10", core_rdata[1*DW +: DW]); end
    cycle();
    checks++; if (core_ack !== 4'b0000) begin errors++; $display("FAIL single_ack_excl got %b want 0000", core_ack); end
    clear_inputs();
    cycle();
  endtask

  task automatic test_write_then_read();
    reset_dut();
    set_txn(0, 1'b1, 16'd999, 16'h00AB);
    set_txn(2, 1'b0, 16'd999, 16'h0000);
    #1;
    checks++; if (mem_write !== 1'b1 || mem_address !== 16'd999 || mem_data_in !== 16'h00AB) begin
      errors++; $display("FAIL wr_drive got w%b a%0d d%h want w1 a999 d00ab", mem_write, mem_address, mem_data_in); end
    cycle();
    checks++; if (core_ack !== 4'b0001) begin errors++; $display("FAIL wr_ack0 got %b want 0001", core_ack); end
    cycle();
    checks++; if (core_ack !== 4'b0100) begin errors++; $display("FAIL wr_ack2 got %b want 0100", core_ack); end
    checks++; if (core_rdata[2*DW +: DW] !== 16'h00AB) begin errors++; $display("FAIL wr_rdata2 got %h want 00ab", core_rdata[2*DW +: DW]); end
    checks++; if (mem[999] !== 16'h00AB) begin errors++; $display("FAIL wr_mem got %h want 00ab", mem[999]); end
    core_req[0] = 1'b0;
    cycle();
    clear_inputs();
    cycle();
  endtask

  task automatic test_full_contention();
    logic [N-1:0] want;
    reset_dut();
    for (int i = 0; i < N; i++) set_txn(i, 1'b0, AW'(i), 16'd0);
    for (int c = 1; c <= N; c++) begin
      for (int i = 0; i < N; i++) if (ack_prev[i]) core_req[i] = 1'b0;
      cycle();
      want = '0;
      want[c-1] = 1'b1;
      checks++; if (core_ack !== want) begin errors++; $display("FAIL contention_ack c%0d got %b want %b", c, core_ack, want); end
      checks++; if (core_rdata[(c-1)*DW +: DW] !== DW'(c)) begin
        errors++; $display("FAIL contention_rdata c%0d got %0d want %0d", c, core_rdata[(c-1)*DW +: DW], c); end
    end
    clear_inputs();
    cycle();
  endtask

  task automatic test_fairness();
    int cnt2;
    logic [N-1:0] want;
    reset_dut();
    set_txn(0, 1'b0, AW'($urandom_range(0, 15)), 16'd0);
    set_txn(2, 1'b0, AW'($urandom_range(0, 15)), 16'd0);
    for (int c = 1; c <= 8; c++) begin
      if (ack_prev[0]) set_txn(0, 1'b0, AW'($urandom_range(0, 15)), 16'd0);
      if (ack_prev[2]) set_txn(2, 1'b0, AW'($urandom_range(0, 15)), 16'd0);
      cycle();
      want = (c % 2 == 1) ? 4'b0001 : 4'b0100;
      checks++; if (core_ack !== want) begin errors++; $display("FAIL fair2_ack c%0d got %b want %b", c, core_ack, want); end
      for (int i = 0; i < N; i++) begin
        checks++; if (core_rdata[i*DW +: DW] !== exp_rdata[i]) begin
          errors++; $display("FAIL fair2_rdata core%0d got %h want %h", i, core_rdata[i*DW +: DW], exp_rdata[i]); end
      end
    end
    reset_dut();
    cnt2 = 0;
    for (int i = 0; i < 3; i++) set_txn(i, 1'b0, AW'(i), 16'd0);
    for (int c = 1; c <= 12; c++) begin
      for (int i = 0; i < 3; i++) if (ack_prev[i]) set_txn(i, 1'b0, AW'($urandom_range(0, 15)), 16'd0);
      cycle();
      if (core_ack[2]) cnt2++;
      checks++; if (core_ack !== exp_ack) begin errors++; $display("FAIL fair3_ack c%0d got %b want %b", c, core_ack, exp_ack); end
    end
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    checks++; if (cnt2 != 0) begin errors++; $display("FAIL fair3_core2_grants got %0d want 0", cnt2); end
`else
    checks++; if (cnt2 != 4) begin errors++; $display("FAIL fair3_core2_grants got %0d want 4", cnt2); end
`endif
    clear_inputs();
    cycle();
  endtask

  task automatic test_reset_mid_op();
    reset_dut();
    set_txn(1, 1'b0, 16'd100, 16'd0);
    cycle();
    checks++; if (core_ack !== 4'b0010) begin errors++; $display("FAIL midrst_pre_ack got %b want 0010", core_ack); end
    reset = 1'b1;
    set_txn(3, 1'b1, 16'd50, 16'd55);
    #1;
    checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL midrst_drive got w%b r%b want w0 r0", mem_write, mem_read); end
    cycle();
    checks++; if (core_ack !== 4'b0000) begin errors++; $display("FAIL midrst_ack got %b want 0000", core_ack); end
    checks++; if (mem[50] !== 16'd77) begin errors++; $display("FAIL midrst_mem got %0d want 77", mem[50]); end
    checks++; if (core_rdata[1*DW +: DW] !== 16'd0) begin errors++; $display("FAIL midrst_rdata got %0d want 0", core_rdata[1*DW +: DW]); end
    reset = 1'b0;
    set_txn(0, 1'b0, 16'd0, 16'd0);
    cycle();
    checks++; if (core_ack !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got %b want 0001", core_ack); end
    clear_inputs();
    cycle();
  endtask

  task automatic test_idle();
    clear_inputs();
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL idle_drive c%0d got w%b r%b want w0 r0", c, mem_write, mem_read); end
      cycle();
      for (int i = 0; i < N; i++) begin
        checks++; if (core_rdata[i*DW +: DW] !== exp_rdata[i]) begin
          errors++; $display("FAIL idle_rdata core%0d got %h want %h", i, core_rdata[i*DW +: DW], exp_rdata[i]); end
      end
    end
  endtask

  task automatic test_random();
    int g;
    logic ew, er;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!core_req[i]) begin
          if ($urandom_range(0, 2) == 0) set_txn(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
        end else if (ack_prev[i]) begin
          if ($urandom_range(0, 1) == 1) set_txn(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
          else core_req[i] = 1'b0;
        end
      end
      #1;
      g = model_grant();
      ew = 1'b0; er = 1'b0; ea = '0; ed = '0;
      if (g >= 0) begin
        ew = core_we[g]; er = ~core_we[g];
        ea = core_addr[g*AW +: AW]; ed = core_wdata[g*DW +: DW];
      end
      checks++; if (mem_write !== ew || mem_read !== er || mem_address !== ea || mem_data_in !== ed) begin
        errors++; $display("FAIL rand_drive c%0d got w%b r%b a%h d%h want w%b r%b a%h d%h",
                           c, mem_write, mem_read, mem_address, mem_data_in, ew, er, ea, ed); end
      cycle();
      checks++; if (core_ack !== exp_ack) begin errors++; $display("FAIL rand_ack c%0d got %b want %b", c, core_ack, exp_ack); end
      for (int i = 0; i < N; i++) begin
        checks++; if (core_rdata[i*DW +: DW] !== exp_rdata[i]) begin
          errors++; $display("FAIL rand_rdata c%0d core%0d got %h want %h", c, i, core_rdata[i*DW +: DW], exp_rdata[i]); end
      end
    end
    clear_inputs();
    cycle();
    for (int a = 0; a < 16; a++) begin
      checks++; if (mem[a] !== ref_mem[a]) begin errors++; $display("FAIL rand_mem addr%0d got %h want %h", a, mem[a], ref_mem[a]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    exp_ack = '0; ack_prev = '0; exp_last = N - 1;
    for (int i = 0; i < N; i++) exp_rdata[i] = '0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write_then_read();
    test_full_contention();
    test_fairness();
    test_reset_mid_op();
    test_idle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Multi-core request arbiter sitting directly upstream of `data_memory` in the matrix-multiplication datapath. It accepts independent read/write requests from `NUM_CORES` processing cores and grants exactly one per cycle to the shared single-port data memory. It drives the memory's `write`/`read`/`address`/`data_in` pins and returns registered read data and a one-cycle acknowledge to the granted core.

## Interface
- `NUM_CORES`, 4: number of requesting cores (2–8).
- `ADDR_W`, 16: address width, matches `data_memory` address.
- `DATA_W`, 16: data width, matches `data_memory` data.

Core-side buses are flattened: core *i* occupies slice `[i*W +: W]`.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `core_req`  in  NUM_CORES  per-core request; held high until that core's `core_ack`.
- `core_we`  in  NUM_CORES  per-core write enable (1 = write, 0 = read).
- `core_addr`  in  NUM_CORES*ADDR_W  per-core address.
- `core_wdata`  in  NUM_CORES*DATA_W  per-core write data.
- `core_ack`  out  NUM_CORES  registered one-cycle completion pulse per core.
- `core_rdata`  out  NUM_CORES*DATA_W  registered per-core read data.
- `mem_write`  out  1  to `data_memory.write`.
- `mem_read`  out  1  to `data_memory.read`.
- `mem_address`  out  ADDR_W  to `data_memory.address`.
- `mem_data_in`  out  DATA_W  to `data_memory.data_in`.
- `mem_data_out`  in  DATA_W  from `data_memory.data_out` (combinational read).

## Operation
- Eligibility: core *i* is eligible when `core_req[i] & ~core_ack[i]`. A core whose ack is high this cycle is never granted; its request lines still hold the completed transaction.
- Arbitration: combinational, one grant per cycle. Round-robin: search starts at `last_grant+1` (mod NUM_CORES) and picks the first eligible core. `last_grant` updates to the granted index on any cycle with a grant and holds otherwise.
- Memory drive in grant cycle: `mem_address`/`mem_data_in` = granted core's slices. `mem_write` = `core_we[g]`, `mem_read` = `~core_we[g]`. With no grant: `mem_write`=0, `mem_read`=0, address/data = 0.
- Completion: on the next edge, `core_ack[g]` ← 1 and all other acks ← 0. On a read, `core_rdata[g]` ← `mem_data_out`. On a write, `core_rdata[g]` holds. Non-granted `core_rdata` slices always hold.
- Core protocol: hold req/we/addr/wdata stable from assertion through the ack cycle. On the cycle after ack, the core either drops req or presents a new transaction.
- Reset values: `core_ack`=0, all `core_rdata`=0, `last_grant`=NUM_CORES-1 so core 0 wins first. While `reset` is high, `mem_write`=`mem_read`=0, so no memory write occurs.

## Timing
- Request-to-ack latency: 1 cycle minimum, i.e. a grant in cycle N gives ack and rdata in cycle N+1. Worst case under full contention: NUM_CORES cycles.
- Memory write commits at the end of grant cycle N. A read by another core granted in N+1 returns the new value.
- Throughput: one memory access per cycle aggregate. Each core gets at most one access per 2 cycles because of the ack-cycle exclusion.
- Reset mid-transaction: a grant in the reset cycle is discarded with no write and no ack. A pending ack is cleared. Cores must re-request after reset drops.
- Simultaneous read and write to the same address by different cores: serialized by grant order. No forwarding.

## Configuration
- `DATA_MEM_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index eligible core wins. `last_grant` is not implemented.
- `DATA_MEM_ARB_FIXED_PRIO_EN` undefined (default): round-robin as above.

## Test plan
- Single read: memory[100]=10, core 1 req read addr 100 at cycle 0 -> `core_ack[1]`=1 at cycle 1, `core_rdata[1]`=10. Other acks stay 0.
- Write-then-read: core 0 writes 16'h00AB to addr 999 in cycle 0. Core 2 reads 999 from cycle 0 -> core 0 acks in cycle 1, core 2 acks in cycle 2 with rdata=16'h00AB.
- Full contention after reset: all 4 cores read addrs 0–3 (holding 1,2,3,4) at cycle 0, each dropping req after ack -> acks in cycles 1,2,3,4 for cores 0,1,2,3 with rdata 1,2,3,4.
- Fairness: cores 0 and 2 continuously re-request (new req the cycle after ack) -> grants alternate 0,2,0,2 and neither waits more than 1 cycle. With `DATA_MEM_ARB_FIXED_PRIO_EN` the sequence is still 0,2,0,2 because of ack exclusion. Add core 1 and core 2 starves under fixed priority only.
- Reset mid-op: core 3 write of 55 to addr 50 granted in the same cycle `reset`=1 -> memory[50] unchanged, `core_ack` all 0. First post-reset grant goes to core 0.
- Idle: no req for 10 cycles -> `mem_write`=`mem_read`=0, `core_rdata` unchanged.
